// File: rtl/dm_cache_pkg.sv
// Shared types and default geometry for the direct-mapped read cache.
package dm_cache_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_INDEX_W  = 8;
    localparam int unsigned DEF_OFFSET_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        RESPOND,
        FLUSH
    } state_t;

endpackage

// File: rtl/dm_cache_array.sv
// Tag/valid/data storage: asynchronous read, per-word line fill, per-index valid clear.
module dm_cache_array #(
    parameter int unsigned INDEX_W  = 8,
    parameter int unsigned OFFSET_W = 4,
    parameter int unsigned TAG_W    = 20,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                tag_we,
    input  logic [TAG_W-1:0]    tag_data,
    input  logic                clr_en,
    input  logic [INDEX_W-1:0]  clr_index
);

    localparam int unsigned LINES = 1 << INDEX_W;
    localparam int unsigned WORDS = 1 << OFFSET_W;

    logic [DATA_W-1:0] data_mem [LINES*WORDS];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid_q;

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_offset}];

    // Tag and data contents are never reset; only the valid bits are.
    always_ff @(posedge clk) begin
        if (wr_en)
            data_mem[{wr_index, wr_offset}] <= wr_data;
        if (tag_we)
            tag_mem[wr_index] <= tag_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (clr_en)
                valid_q[clr_index] <= 1'b0;
            if (tag_we)
                valid_q[wr_index] <= 1'b1;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Read-only direct-mapped cache controller: lookup FSM, line refill, sequential flush, hit/miss counters.
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned INDEX_W  = DEF_INDEX_W,
    parameter int unsigned OFFSET_W = DEF_OFFSET_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              flush,
    output logic              flush_busy,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [OFFSET_W-1:0] beat_q;
    logic [INDEX_W-1:0]  flush_idx_q;

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  addr_index;
    logic [OFFSET_W-1:0] addr_offset;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic                hit;
    logic                wr_en, tag_we, clr_en;

    assign addr_tag     = addr_q[ADDR_W-1:INDEX_W+OFFSET_W];
    assign addr_index   = addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign addr_offset  = addr_q[OFFSET_W-1:0];
    assign hit          = rd_valid && (rd_tag == addr_tag);
    assign mem_req_addr = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

    dm_cache_array #(
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .TAG_W    (TAG_W),
        .DATA_W   (DATA_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index  (addr_index),
        .rd_offset (addr_offset),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (resp_data),
        .wr_en     (wr_en),
        .wr_index  (addr_index),
        .wr_offset (beat_q),
        .wr_data   (mem_rsp_data),
        .tag_we    (tag_we),
        .tag_data  (addr_tag),
        .clr_en    (clr_en),
        .clr_index (flush_idx_q)
    );

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_hit      = 1'b0;
        mem_req_valid = 1'b0;
        flush_busy    = 1'b0;
        wr_en         = 1'b0;
        tag_we        = 1'b0;
        clr_en        = 1'b0;
        case (state_q)
            IDLE: begin
                // rst_n gate keeps req_ready low while reset is held.
                req_ready = rst_n && !flush;
                if (flush)
                    state_d = FLUSH;
                else if (req_valid)
                    state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    resp_hit   = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready)
                    state_d = REFILL;
            end
            REFILL: begin
                if (mem_rsp_valid) begin
                    wr_en = 1'b1;
                    if (beat_q == '1) begin
                        tag_we  = 1'b1;
                        state_d = RESPOND;
                    end
                end
            end
            RESPOND: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            FLUSH: begin
                flush_busy = 1'b1;
                clr_en     = 1'b1;
                if (flush_idx_q == '1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            beat_q      <= '0;
            flush_idx_q <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid && !flush)
                addr_q <= req_addr;
            if (state_q == MISS_REQ && mem_req_ready)
                beat_q <= '0;
            else if (state_q == REFILL && mem_rsp_valid)
                beat_q <= beat_q + 1'b1;
            if (state_q == FLUSH)
                flush_idx_q <= flush_idx_q + 1'b1;
            if (state_q == LOOKUP) begin
                if (hit && hit_cnt != '1)
                    hit_cnt <= hit_cnt + 1'b1;
                if (!hit && miss_cnt != '1)
                    miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed plus randomized bench for dm_cache_ctrl against a line-level cache model.
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_hit;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        flush;
    logic        flush_busy;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    // Model: which tag each line holds (if any) and its 16 words.
    bit          m_valid [256];
    logic [19:0] m_tag   [256];
    logic [31:0] m_data  [256][16];
    int          m_hits;
    int          m_misses;

    always #5 clk = ~clk;

    dm_cache_ctrl #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .INDEX_W  (8),
        .OFFSET_W (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_hit      (resp_hit),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .flush         (flush),
        .flush_busy    (flush_busy),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    endtask

    // One complete request. Called just after a falling edge with the DUT idle.
    task automatic do_access(input logic [31:0] addr, input bit pattern,
                             input int stall, input bit stray, input int abort_beat);
        logic [7:0]  idx;
        logic [19:0] tg;
        logic [3:0]  off;
        logic [31:0] line [16];
        bit          exp_hit;
        int          gap;
        idx = addr[11:4];
        tg  = addr[31:12];
        off = addr[3:0];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);

        req_valid = 1'b1;
        req_addr  = addr;
        #1 chk("req_ready_idle", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (exp_hit) begin
            m_hits++;
            chk("hit_resp_valid", resp_valid, 1);
            chk("hit_resp_hit", resp_hit, 1);
            chk("hit_resp_data", resp_data, m_data[idx][off]);
            chk("hit_no_mem_req", mem_req_valid, 0);
            @(negedge clk);
            chk("hit_cnt", hit_cnt, m_hits);
            chk("hit_no_mem_req_after", mem_req_valid, 0);
            return;
        end

        m_misses++;
        chk("miss_no_resp", resp_valid, 0);
        @(negedge clk);
        chk("mem_req_valid", mem_req_valid, 1);
        chk("mem_req_addr", mem_req_addr, {addr[31:4], 4'h0});
        chk("miss_cnt", miss_cnt, m_misses);
        for (int s = 0; s < stall; s++) begin
            mem_rsp_valid = stray;
            mem_rsp_data  = $urandom;
            @(negedge clk);
            chk("stall_req_valid", mem_req_valid, 1);
            chk("stall_req_addr", mem_req_addr, {addr[31:4], 4'h0});
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("refill_req_dropped", mem_req_valid, 0);

        for (int b = 0; b < 16; b++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
            if (b == abort_beat) begin
                rst_n = 1'b0;
                #1;
                chk("rst_req_ready", req_ready, 0);
                chk("rst_resp_valid", resp_valid, 0);
                chk("rst_resp_hit", resp_hit, 0);
                chk("rst_mem_req_valid", mem_req_valid, 0);
                chk("rst_flush_busy", flush_busy, 0);
                chk("rst_hit_cnt", hit_cnt, 0);
                chk("rst_miss_cnt", miss_cnt, 0);
                model_clear();
                m_hits = 0;
                m_misses = 0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            line[b] = pattern ? (32'h0000_A000 + b) : $urandom;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = line[b];
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (b < 15) chk("refill_no_resp", resp_valid, 0);
        end
        chk("fill_resp_valid", resp_valid, 1);
        chk("fill_resp_hit", resp_hit, 0);
        chk("fill_resp_data", resp_data, line[off]);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        for (int w = 0; w < 16; w++) m_data[idx][w] = line[w];
        @(negedge clk);
        chk("fill_resp_pulse", resp_valid, 0);
    endtask

    initial begin
        int n_busy;
        int ready_seen;
        logic [31:0] a;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        flush = 1'b0;
        model_clear();
        m_hits = 0;
        m_misses = 0;

        repeat (3) @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_mem_req_valid", mem_req_valid, 0);
        chk("reset_flush_busy", flush_busy, 0);
        chk("reset_hit_cnt", hit_cnt, 0);
        chk("reset_miss_cnt", miss_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss, then hit on the same word
        do_access(32'h0000_1234, 1'b1, 0, 1'b0, -1);
        chk("cold_miss_cnt", miss_cnt, 1);
        do_access(32'h0000_1234, 1'b1, 0, 1'b0, -1);
        chk("repeat_hit_cnt", hit_cnt, 1);

        // Conflict on index 0x23
        do_access(32'h0010_1234, 1'b0, 0, 1'b0, -1);
        do_access(32'h0000_1234, 1'b1, 0, 1'b0, -1);
        chk("conflict_miss_cnt", miss_cnt, 3);

        // Memory backpressure with stray fill beats
        do_access(32'h0020_5678, 1'b0, 5, 1'b1, -1);
        do_access(32'h0020_567C, 1'b0, 0, 1'b0, -1);

        // Flush wins over a simultaneous request
        flush = 1'b1;
        req_valid = 1'b1;
        req_addr = 32'h0000_1234;
        #1 chk("flush_req_ready", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        n_busy = 0;
        ready_seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (!flush_busy) break;
            n_busy++;
            if (req_ready) ready_seen++;
            @(negedge clk);
        end
        chk("flush_cycles", n_busy, 256);
        chk("flush_ready_seen", ready_seen, 0);
        chk("flush_no_resp", resp_valid, 0);
        model_clear();
        do_access(32'h0000_1234, 1'b1, 0, 1'b0, -1);

        // Reset in the middle of a refill
        do_access(32'h0030_4564, 1'b1, 0, 1'b0, 7);
        do_access(32'h0030_4564, 1'b1, 0, 1'b0, -1);
        chk("post_abort_miss_cnt", miss_cnt, 1);

        // Random traffic over a small tag/index pool to mix hits and conflicts
        for (int t = 0; t < 60; t++) begin
            a = {$urandom_range(0, 3) == 0 ? 20'h00000 : 20'(($urandom_range(1, 3)) << 8),
                 8'($urandom_range(0, 3) * 8'h41), 4'($urandom_range(0, 15))};
            do_access(a, 1'b0, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
        end
        chk("final_hit_cnt", hit_cnt, m_hits);
        chk("final_miss_cnt", miss_cnt, m_misses);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_cache_ctrl.md
DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
  ADDR_W    32  word-address width
  DATA_W    32  data word width
  INDEX_W   8   line-index bits (2^INDEX_W lines)
  OFFSET_W  4   word-offset bits (2^OFFSET_W words per line)
  TAG_W     ADDR_W-INDEX_W-OFFSET_W, derived, never overridden
REQ-002 Address split SHALL be tag=[ADDR_W-1 : INDEX_W+OFFSET_W], index=[INDEX_W+OFFSET_W-1 : OFFSET_W], offset=[OFFSET_W-1 : 0].
REQ-003 Ports SHALL be (one per line: name, direction, width, meaning):
  clk            in   1        single clock, rising edge
  rst_n          in   1        asynchronous reset, active-low
  req_valid      in   1        lookup request
  req_ready      out  1        request accepted when req_valid & req_ready
  req_addr       in   ADDR_W   word address
  resp_valid     out  1        one-cycle response pulse
  resp_data      out  DATA_W   requested word
  resp_hit       out  1        1 = hit, 0 = served by refill
  mem_req_valid  out  1        line-fill request
  mem_req_ready  in   1        memory accepts fill request
  mem_req_addr   out  ADDR_W   line-aligned address, offset bits zero
  mem_rsp_valid  in   1        fill beat valid
  mem_rsp_data   in   DATA_W   fill beat data
  flush          in   1        level request: invalidate all lines
  flush_busy     out  1        flush in progress
  hit_cnt        out  32       saturating hit counter
  miss_cnt       out  32       saturating miss counter

Function
REQ-004 The block SHALL be a read-only, direct-mapped cache with FSM states IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND and FLUSH.
REQ-005 req_ready SHALL be 1 only in IDLE with flush low; on acceptance, req_addr SHALL be registered and the state SHALL go to LOOKUP.
REQ-006 In LOOKUP, a hit (valid[index] & tag match) SHALL drive resp_valid=1, resp_hit=1 and resp_data=data[index][offset] in that cycle (latency 1 from acceptance), increment hit_cnt and return the FSM to IDLE.
REQ-007 A miss in LOOKUP SHALL increment miss_cnt and go to MISS_REQ.
REQ-008 In MISS_REQ, mem_req_valid SHALL be 1 with mem_req_addr = {tag, index, 0} held stable until mem_req_ready; on the handshake the FSM SHALL go to REFILL with the beat counter at 0.
REQ-009 In REFILL, each mem_rsp_valid beat SHALL write word[beat] of the line, with beats arriving in order 0..2^OFFSET_W-1; mem_rsp_valid SHALL be ignored in all other states.
REQ-010 On the last beat, the tag SHALL be written and valid[index] set, and the FSM SHALL go to RESPOND.
REQ-011 RESPOND SHALL drive resp_valid=1, resp_hit=0, resp_data = refilled word at offset for one cycle, then return to IDLE.
REQ-012 There SHALL be no response backpressure; resp_data SHALL be don't-care when resp_valid=0.
REQ-013 flush SHALL be honoured only in IDLE and SHALL take priority over a simultaneous req_valid.
REQ-014 FLUSH SHALL clear one valid bit per cycle, indices 0..2^INDEX_W-1 in order (2^INDEX_W cycles), with flush_busy=1 throughout and req_ready=0, then return to IDLE.
REQ-015 A flush asserted outside IDLE SHALL be deferred until IDLE is reached.
REQ-016 hit_cnt and miss_cnt SHALL saturate at 0xFFFF_FFFF.

Reset
REQ-017 rst_n low SHALL asynchronously force state IDLE, all valid bits 0, beat and flush counters 0, hit_cnt and miss_cnt 0, and req_ready, resp_valid, resp_hit, mem_req_valid and flush_busy all 0.
REQ-018 Tag and data arrays SHALL NOT be reset.
REQ-019 Reset during REFILL or FLUSH SHALL abandon the operation; no line SHALL be left valid.

Structure
REQ-020 Package dm_cache_pkg SHALL hold the FSM state typedef and the default parameter constants.
REQ-021 Tag, valid and data storage SHALL be in sub-module dm_cache_array (one read port, one line-write port, per-index valid clear); the FSM, counters and handshakes SHALL stay in dm_cache_ctrl.

Verification
REQ-022 Cold miss at req_addr 0x0000_1234 -> mem_req_addr 0x0000_1230; 16 beats data 0xA000+beat -> resp_data 0xA004, resp_hit 0, miss_cnt 1.
REQ-023 Repeat of 0x0000_1234 -> resp_valid the cycle after acceptance, resp_data 0xA004, resp_hit 1, hit_cnt 1, no mem_req_valid.
REQ-024 Conflict: 0x0010_1234 (same index 0x23, new tag) misses and replaces the line; the following 0x0000_1234 misses again; miss_cnt 3.
REQ-025 mem_req_ready held 0 for 5 cycles -> mem_req_valid and mem_req_addr remain stable; stray mem_rsp_valid in MISS_REQ is ignored.
REQ-026 flush and req_valid high together in IDLE -> req_ready 0, flush_busy high for exactly 256 cycles; afterwards 0x0000_1234 misses.
REQ-027 rst_n pulsed low at REFILL beat 7 -> all outputs 0 immediately; the next access to the same address misses.
